// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RISC-V datapath.
// The controller side (master) receives IR fields and ALU flags and drives
// every write enable and mux select; the datapath side (slave) is the mirror.
interface multicycle_controller_if;

    // Datapath -> controller
    logic       zero;
    logic       sign;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    // Controller -> datapath
    logic       PCwrite;
    logic       oldPCwrite;
    logic       IRwrite;
    logic       memwrite;
    logic       regwrite;
    logic       adrsrc;
    logic [1:0] ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [1:0] resultsrc;
    logic [2:0] IMMsrc;
    logic [2:0] ALUcontrol;
    logic       illegal;

    modport master (
        input  zero, sign, opc, f3, f7,
        output PCwrite, oldPCwrite, IRwrite, memwrite, regwrite, adrsrc,
               ALUsrcA, ALUsrcB, resultsrc, IMMsrc, ALUcontrol, illegal
    );

    modport slave (
        output zero, sign, opc, f3, f7,
        input  PCwrite, oldPCwrite, IRwrite, memwrite, regwrite, adrsrc,
               ALUsrcA, ALUsrcB, resultsrc, IMMsrc, ALUcontrol, illegal
    );

endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RISC-V datapath. One state per cycle;
// outputs are combinational from state, IR fields and (BRANCH) ALU flags.
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined, illegal encodings
// park the FSM in HALT with a sticky 'illegal' flag; otherwise they act as NOPs.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_RD, S_MEM_WB,
        S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_JALR_PC, S_LINK_WB, S_LUI, S_HALT
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] A_PC = 2'd0, A_OLDPC = 2'd1, A_REG = 2'd2;
    localparam logic [1:0] B_REG = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
    localparam logic [1:0] RES_ALUREG = 2'd0, RES_ALUOUT = 2'd1, RES_MDR = 2'd2, RES_IMM = 2'd3;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR = 3'b011, ALU_XOR = 3'b100, ALU_SLT = 3'b101;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    state_t     state, state_next;
    logic       f3_alu_ok, illegal_r, illegal_i, illegal_br, br_cond, wb_kill;
    logic [2:0] alu_r, alu_i;
    logic       unused_f7;

    // Only f7[5] selects anything; the remaining bits are don't-care here.
    assign unused_f7 = ^{bus.f7[6], bus.f7[4:0]};

    function automatic logic [2:0] alu_from_f3(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b100:  return ALU_XOR;
            3'b010:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Legality of the current IR fields, ALU op selection and branch condition
    always_comb begin
        f3_alu_ok  = bus.f3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
        illegal_r  = !f3_alu_ok || (bus.f7[5] && (bus.f3 != 3'b000));
        illegal_i  = !f3_alu_ok;
        illegal_br = !(bus.f3 inside {3'b000, 3'b001, 3'b100, 3'b101});
        alu_r      = alu_from_f3(bus.f3, bus.f7[5]);
        alu_i      = alu_from_f3(bus.f3, 1'b0);
        case (bus.f3)
            3'b000:  br_cond = bus.zero;
            3'b001:  br_cond = !bus.zero;
            3'b100:  br_cond = bus.sign;
            3'b101:  br_cond = !bus.sign;
            default: br_cond = 1'b0;
        endcase
    end

    // State register; reset restarts at FETCH
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag: set on entry to HALT, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)                       illegal_q <= 1'b0;
        else if (state_next == S_HALT) illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q;
    assign wb_kill     = 1'b0;
`else
    // Remember an illegal EXEC encoding so the following ALU_WB drops its write
    always_ff @(posedge clk) begin
        if (rst)                  wb_kill <= 1'b0;
        else if (state == S_EXEC_R) wb_kill <= illegal_r;
        else if (state == S_EXEC_I) wb_kill <= illegal_i;
    end

    assign bus.illegal = 1'b0;
`endif

    // Next-state and control decode; everything stays 0 while rst is high
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        bus.PCwrite    = 1'b0;
        bus.oldPCwrite = 1'b0;
        bus.IRwrite    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.adrsrc     = 1'b0;
        bus.ALUsrcA    = A_PC;
        bus.ALUsrcB    = B_REG;
        bus.resultsrc  = RES_ALUREG;
        bus.IMMsrc     = IMM_I;
        bus.ALUcontrol = ALU_ADD;
        state_next     = S_FETCH;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    bus.IRwrite    = 1'b1;
                    bus.PCwrite    = 1'b1;
                    bus.oldPCwrite = 1'b1;
                    bus.ALUsrcB    = B_FOUR;
                    bus.resultsrc  = RES_ALUOUT;
                    state_next     = S_DECODE;
                end
                S_DECODE: begin
                    // ALUreg captures the branch/jal target computed here.
                    bus.ALUsrcA = A_OLDPC;
                    bus.ALUsrcB = B_IMM;
                    bus.IMMsrc  = (bus.opc == OPC_JAL) ? IMM_J : IMM_B;
                    case (bus.opc)
                        OPC_R:               state_next = S_EXEC_R;
                        OPC_I:               state_next = S_EXEC_I;
                        OPC_LOAD, OPC_STORE: state_next = S_MEM_ADR;
                        OPC_BRANCH:          state_next = S_BRANCH;
                        OPC_JAL:             state_next = S_JAL;
                        OPC_JALR:            state_next = S_JALR;
                        OPC_LUI:             state_next = S_LUI;
                        default:             state_next = TRAP ? S_HALT : S_FETCH;
                    endcase
                end
                S_EXEC_R: begin
                    bus.ALUsrcA    = A_REG;
                    bus.ALUsrcB    = B_REG;
                    bus.ALUcontrol = alu_r;
                    state_next     = (TRAP && illegal_r) ? S_HALT : S_ALU_WB;
                end
                S_EXEC_I: begin
                    bus.ALUsrcA    = A_REG;
                    bus.ALUsrcB    = B_IMM;
                    bus.IMMsrc     = IMM_I;
                    bus.ALUcontrol = alu_i;
                    state_next     = (TRAP && illegal_i) ? S_HALT : S_ALU_WB;
                end
                S_ALU_WB: begin
                    bus.regwrite = !wb_kill;
                end
                S_MEM_ADR: begin
                    bus.ALUsrcA = A_REG;
                    bus.ALUsrcB = B_IMM;
                    bus.IMMsrc  = (bus.opc == OPC_STORE) ? IMM_S : IMM_I;
                    state_next  = (bus.opc == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    bus.adrsrc = 1'b1;
                    state_next = S_MEM_WB;
                end
                S_MEM_WB: begin
                    bus.resultsrc = RES_MDR;
                    bus.regwrite  = 1'b1;
                end
                S_MEM_WR: begin
                    bus.adrsrc   = 1'b1;
                    bus.memwrite = 1'b1;
                end
                S_BRANCH: begin
                    // Illegal f3 never takes the branch.
                    bus.ALUsrcA    = A_REG;
                    bus.ALUsrcB    = B_REG;
                    bus.ALUcontrol = ALU_SUB;
                    bus.PCwrite    = br_cond && !illegal_br;
                    state_next     = (TRAP && illegal_br) ? S_HALT : S_FETCH;
                end
                S_JAL: begin
                    // PC takes the target from ALUreg; ALU forms the link address.
                    bus.PCwrite = 1'b1;
                    bus.ALUsrcA = A_OLDPC;
                    bus.ALUsrcB = B_FOUR;
                    state_next  = S_LINK_WB;
                end
                S_JALR: begin
                    bus.ALUsrcA = A_REG;
                    bus.ALUsrcB = B_IMM;
                    bus.IMMsrc  = IMM_I;
                    state_next  = S_JALR_PC;
                end
                S_JALR_PC: begin
                    bus.PCwrite = 1'b1;
                    bus.ALUsrcA = A_OLDPC;
                    bus.ALUsrcB = B_FOUR;
                    state_next  = S_LINK_WB;
                end
                S_LINK_WB: begin
                    bus.regwrite = 1'b1;
                end
                S_LUI: begin
                    bus.IMMsrc    = IMM_U;
                    bus.resultsrc = RES_IMM;
                    bus.regwrite  = 1'b1;
                end
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A per-cycle vector table
// (inputs plus expected control word) is replayed through a scoreboard queue;
// hand-written sequences cover reset aborts and illegal encodings.
// Honours ILLEGAL_TRAP_EN when the bundle is built with it defined.
module tb_multicycle_controller;

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_BAD = 7'b1111111;
    localparam logic [6:0] F7_0 = 7'b0000000, F7_1 = 7'b0100000;

    localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_A = 2'd2;
    localparam logic [1:0] B_B = 2'd0, B_IMM = 2'd1, B_4 = 2'd2;
    localparam logic [1:0] R_ALUREG = 2'd0, R_ALUOUT = 2'd1, R_MDR = 2'd2, R_IMM = 2'd3;
    localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2, I_J = 3'd3, I_U = 3'd4;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3, XOR = 3'd4, SLT = 3'd5;

    typedef struct packed {
        logic       PCwrite, oldPCwrite, IRwrite, memwrite, regwrite, adrsrc;
        logic [1:0] ALUsrcA, ALUsrcB, resultsrc;
        logic [2:0] IMMsrc, ALUcontrol;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zero, sign;
        ctrl_t      exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t  table_q[$];
    ctrl_t exp_q[$];
    string name_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    // Current instruction context used when building rows.
    logic [6:0] cur_opc;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    logic       cur_zero, cur_sign;
    string      cur_name;
    int         cur_idx;

    function automatic ctrl_t mk(input logic pcw, opw, irw, mw, rw, adr,
                                 input logic [1:0] a, b, res,
                                 input logic [2:0] imm, alu, input logic ill);
        ctrl_t c;
        c = '{pcw, opw, irw, mw, rw, adr, a, b, res, imm, alu, ill};
        return c;
    endfunction

    function automatic ctrl_t c_zero();
        return mk(0, 0, 0, 0, 0, 0, A_PC, B_B, R_ALUREG, I_I, ADD, 0);
    endfunction
    function automatic ctrl_t c_halt();
        return mk(0, 0, 0, 0, 0, 0, A_PC, B_B, R_ALUREG, I_I, ADD, 1);
    endfunction
    function automatic ctrl_t c_fetch();
        return mk(1, 1, 1, 0, 0, 0, A_PC, B_4, R_ALUOUT, I_I, ADD, 0);
    endfunction
    function automatic ctrl_t c_decode(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 0, 0, A_OLD, B_IMM, R_ALUREG, imm, ADD, 0);
    endfunction
    function automatic ctrl_t c_alu(input logic [1:0] a, b, input logic [2:0] imm, op);
        return mk(0, 0, 0, 0, 0, 0, a, b, R_ALUREG, imm, op, 0);
    endfunction
    function automatic ctrl_t c_wb(input logic [1:0] res);
        return mk(0, 0, 0, 0, 1, 0, A_PC, B_B, res, I_I, ADD, 0);
    endfunction
    function automatic ctrl_t c_br(input logic taken);
        return mk(taken, 0, 0, 0, 0, 0, A_A, B_B, R_ALUREG, I_I, SUB, 0);
    endfunction
    function automatic ctrl_t c_link_pc();
        return mk(1, 0, 0, 0, 0, 0, A_OLD, B_4, R_ALUREG, I_I, ADD, 0);
    endfunction

    function automatic ctrl_t sample();
        return '{bus.PCwrite, bus.oldPCwrite, bus.IRwrite, bus.memwrite, bus.regwrite,
                 bus.adrsrc, bus.ALUsrcA, bus.ALUsrcB, bus.resultsrc, bus.IMMsrc,
                 bus.ALUcontrol, bus.illegal};
    endfunction

    task automatic set_ins(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic zero, input logic sign, input string name);
        cur_opc = opc; cur_f3 = f3; cur_f7 = f7;
        cur_zero = zero; cur_sign = sign; cur_name = name; cur_idx = 0;
    endtask

    function automatic vec_t mkv(input logic r, input ctrl_t e);
        vec_t v;
        v.rst = r; v.opc = cur_opc; v.f3 = cur_f3; v.f7 = cur_f7;
        v.zero = cur_zero; v.sign = cur_sign; v.exp = e;
        v.name = $sformatf("%s[%0d]", cur_name, cur_idx);
        return v;
    endfunction

    task automatic row(input ctrl_t e);
        table_q.push_back(mkv(1'b0, e));
        cur_idx++;
    endtask

    // Drive one cycle's inputs just after the rising edge, compare on the falling edge.
    task automatic apply(input vec_t v);
        ctrl_t got, want;
        string nm;
        #1;
        rst      = v.rst;
        bus.opc  = v.opc;
        bus.f3   = v.f3;
        bus.f7   = v.f7;
        bus.zero = v.zero;
        bus.sign = v.sign;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        got  = sample();
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
        @(posedge clk);
    endtask

    task automatic step(input logic r, input ctrl_t e);
        apply(mkv(r, e));
        cur_idx++;
    endtask

    initial begin
        rst = 1'b1;
        bus.opc = '0; bus.f3 = '0; bus.f7 = '0; bus.zero = 1'b0; bus.sign = 1'b0;

        // ---------------- vector table ----------------
        set_ins(OPC_R, 3'b000, F7_1, 0, 0, "reset");
        table_q.push_back(mkv(1'b1, c_zero()));

        set_ins(OPC_R, 3'b000, F7_1, 0, 0, "r_sub");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_B, I_I, SUB)); row(c_wb(R_ALUREG));
        set_ins(OPC_R, 3'b000, F7_0, 0, 0, "r_add");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_B, I_I, ADD)); row(c_wb(R_ALUREG));
        set_ins(OPC_R, 3'b110, F7_0, 0, 0, "r_or");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_B, I_I, OR)); row(c_wb(R_ALUREG));
        set_ins(OPC_R, 3'b100, F7_0, 0, 0, "r_xor");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_B, I_I, XOR)); row(c_wb(R_ALUREG));
        set_ins(OPC_R, 3'b010, F7_0, 0, 0, "r_slt");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_B, I_I, SLT)); row(c_wb(R_ALUREG));
        set_ins(OPC_I, 3'b000, F7_1, 0, 0, "i_add_f7ign");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_IMM, I_I, ADD)); row(c_wb(R_ALUREG));
        set_ins(OPC_I, 3'b111, F7_0, 0, 0, "i_and");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_IMM, I_I, AND)); row(c_wb(R_ALUREG));
        set_ins(OPC_LW, 3'b010, F7_0, 0, 0, "lw");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_IMM, I_I, ADD));
        row(mk(0, 0, 0, 0, 0, 1, A_PC, B_B, R_ALUREG, I_I, ADD, 0)); row(c_wb(R_MDR));
        set_ins(OPC_SW, 3'b010, F7_0, 0, 0, "sw");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_IMM, I_S, ADD));
        row(mk(0, 0, 0, 1, 0, 1, A_PC, B_B, R_ALUREG, I_I, ADD, 0));
        set_ins(OPC_BR, 3'b001, F7_0, 0, 0, "bne_taken");
        row(c_fetch()); row(c_decode(I_B)); row(c_br(1));
        set_ins(OPC_BR, 3'b001, F7_0, 1, 0, "bne_not");
        row(c_fetch()); row(c_decode(I_B)); row(c_br(0));
        set_ins(OPC_BR, 3'b000, F7_0, 1, 0, "beq_taken");
        row(c_fetch()); row(c_decode(I_B)); row(c_br(1));
        set_ins(OPC_BR, 3'b100, F7_0, 0, 1, "blt_taken");
        row(c_fetch()); row(c_decode(I_B)); row(c_br(1));
        set_ins(OPC_BR, 3'b100, F7_0, 0, 0, "blt_not");
        row(c_fetch()); row(c_decode(I_B)); row(c_br(0));
        set_ins(OPC_BR, 3'b101, F7_0, 0, 1, "bge_not");
        row(c_fetch()); row(c_decode(I_B)); row(c_br(0));
        set_ins(OPC_JAL, 3'b000, F7_0, 0, 0, "jal");
        row(c_fetch()); row(c_decode(I_J)); row(c_link_pc()); row(c_wb(R_ALUREG));
        set_ins(OPC_JALR, 3'b000, F7_0, 0, 0, "jalr");
        row(c_fetch()); row(c_decode(I_B)); row(c_alu(A_A, B_IMM, I_I, ADD));
        row(c_link_pc()); row(c_wb(R_ALUREG));
        set_ins(OPC_LUI, 3'b000, F7_0, 0, 0, "lui");
        row(c_fetch()); row(c_decode(I_B));
        row(mk(0, 0, 0, 0, 1, 0, A_PC, B_B, R_IMM, I_U, ADD, 0));

        @(posedge clk);
        for (int i = 0; i < table_q.size(); i++) apply(table_q[i]);

        // ---------------- reset aborts a load after its address cycle ----------------
        set_ins(OPC_LW, 3'b010, F7_0, 0, 0, "lw_abort");
        step(0, c_fetch()); step(0, c_decode(I_B)); step(0, c_alu(A_A, B_IMM, I_I, ADD));
        step(1, c_zero());
        step(0, c_fetch()); step(0, c_decode(I_B)); step(0, c_alu(A_A, B_IMM, I_I, ADD));
        step(0, mk(0, 0, 0, 0, 0, 1, A_PC, B_B, R_ALUREG, I_I, ADD, 0)); step(0, c_wb(R_MDR));

        // ---------------- reset held during FETCH blocks all enables ----------------
        set_ins(OPC_LUI, 3'b000, F7_0, 0, 0, "rst_fetch");
        step(1, c_zero()); step(0, c_fetch()); step(0, c_decode(I_B));
        step(0, mk(0, 0, 0, 0, 1, 0, A_PC, B_B, R_IMM, I_U, ADD, 0));

`ifdef ILLEGAL_TRAP_EN
        // ---------------- unknown opcode traps into HALT ----------------
        set_ins(OPC_BAD, 3'b000, F7_0, 0, 0, "bad_opc_trap");
        step(0, c_fetch()); step(0, c_decode(I_B));
        for (int i = 0; i < 10; i++) step(0, c_halt());
        step(1, c_halt());
        step(0, c_fetch());
        set_ins(OPC_R, 3'b001, F7_0, 0, 0, "r_bad_f3_trap");
        step(0, c_decode(I_B)); step(0, c_alu(A_A, B_B, I_I, ADD));
        step(0, c_halt()); step(0, c_halt());
        step(1, c_halt());
        step(0, c_fetch());
`else
        // ---------------- illegal encodings behave as NOPs ----------------
        set_ins(OPC_BAD, 3'b000, F7_0, 0, 0, "bad_opc_nop");
        step(0, c_fetch()); step(0, c_decode(I_B));
        set_ins(OPC_R, 3'b001, F7_0, 0, 0, "r_bad_f3");
        step(0, c_fetch()); step(0, c_decode(I_B)); step(0, c_alu(A_A, B_B, I_I, ADD));
        step(0, c_zero());
        set_ins(OPC_R, 3'b111, F7_1, 0, 0, "r_bad_f7");
        step(0, c_fetch()); step(0, c_decode(I_B)); step(0, c_alu(A_A, B_B, I_I, AND));
        step(0, c_zero());
        set_ins(OPC_R, 3'b111, F7_0, 0, 0, "r_and_after_nop");
        step(0, c_fetch()); step(0, c_decode(I_B)); step(0, c_alu(A_A, B_B, I_I, AND));
        step(0, c_wb(R_ALUREG));
        set_ins(OPC_I, 3'b001, F7_0, 0, 0, "i_bad_f3");
        step(0, c_fetch()); step(0, c_decode(I_B)); step(0, c_alu(A_A, B_IMM, I_I, ADD));
        step(0, c_zero());
        set_ins(OPC_BR, 3'b010, F7_0, 1, 1, "br_bad_f3");
        step(0, c_fetch()); step(0, c_decode(I_B)); step(0, c_br(0));
        step(0, c_fetch());
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
